// File: rtl/bw_io_ddr_clk_seq.sv
// bw_io_ddr_clk_seq: DRAM clock-pad group controller.
//
// Turns NCLK pad clock gates on and off one pad at a time, leaving a programmable
// gap between gate events so that supply current changes gradually. A gate only
// changes state while that pad's raw clock is low, so a pad never sees a runt pulse.
// The block also holds an NCLK-bit boundary-scan data register with capture, shift
// and update stages. In scan mode the update stage drives the pads.
//
// Optional feature: define DDR_CLK_DIFF_EN to add the complementary output pad_data_n.
//
// Ports:
//   rclk               rclk domain clock
//   rst_l              asynchronous active-low reset
//   dram_io_clk_enable 1 = ramp clocks up, 0 = ramp clocks down
//   stagger_cyc        cycles between gate events (0 behaves as 1)
//   clk_value          per-pad raw clock level from the generator
//   mode_ctrl          1 = boundary-scan update register drives the pads
//   hiz_n              output enable used in scan mode
//   clock_dr           DR clock enable, sampled on rclk
//   shift_dr           with clock_dr: 1 = shift, 0 = capture
//   update_dr          load the update register from the shift register
//   bsi / bso          scan in (enters bit 0) / scan out (bit NCLK-1)
//   pad_data           registered data to the pad drivers
//   pad_data_n         registered complement (DDR_CLK_DIFF_EN only)
//   pad_oe             registered pad output enables
//   clk_gate           current gate state per pad
//   seq_busy           sequencer is ramping up or down
//   seq_done           sequencer has all gates set

module bw_io_ddr_clk_seq #(
  parameter int unsigned NCLK      = 4,
  parameter int unsigned STAGGER_W = 4
) (
  input  logic                 rclk,
  input  logic                 rst_l,
  input  logic                 dram_io_clk_enable,
  input  logic [STAGGER_W-1:0] stagger_cyc,
  input  logic [NCLK-1:0]      clk_value,
  input  logic                 mode_ctrl,
  input  logic                 hiz_n,
  input  logic                 clock_dr,
  input  logic                 shift_dr,
  input  logic                 update_dr,
  input  logic                 bsi,
  output logic                 bso,
  output logic [NCLK-1:0]      pad_data,
`ifdef DDR_CLK_DIFF_EN
  output logic [NCLK-1:0]      pad_data_n,
`endif
  output logic [NCLK-1:0]      pad_oe,
  output logic [NCLK-1:0]      clk_gate,
  output logic                 seq_busy,
  output logic                 seq_done
);

  localparam int unsigned IdxW = (NCLK > 1) ? $clog2(NCLK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCLK - 1);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampUp   = 2'd1,
    StOn       = 2'd2,
    StRampDown = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [STAGGER_W-1:0] cnt_q, cnt_d;
  logic [NCLK-1:0]      gate_q, gate_d;
  logic [STAGGER_W-1:0] reload;

  logic [NCLK-1:0]      sr_q, sr_d;
  logic [NCLK-1:0]      ur_q, ur_d;
  logic [NCLK:0]        sr_shifted;
  logic [NCLK-1:0]      pad_data_q, pad_data_d;
  logic [NCLK-1:0]      pad_oe_q, pad_oe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Gap after a gate event; stagger_cyc is read only here, so a change applies
  // from the next gate event on.
  assign reload = (stagger_cyc == '0) ? '0 : stagger_cyc - 1'b1;

  // Gate sequencer. In RAMP_UP gates 0..idx-1 are set; in RAMP_DOWN gates 0..idx
  // are set. A reversal picks up from the matching neighbour and keeps cnt, so no
  // gate is ever toggled twice.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gate_d  = gate_q;
    unique case (state_q)
      StIdle: begin
        if (dram_io_clk_enable) begin
          state_d = StRampUp;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StRampUp: begin
        if (!dram_io_clk_enable) begin
          if (idx_q == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StRampDown;
            idx_d   = idx_q - 1'b1;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!clk_value[idx_q]) begin
          gate_d[idx_q] = 1'b1;
          cnt_d         = reload;
          if (idx_q == LastIdx) begin
            state_d = StOn;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StOn: begin
        if (!dram_io_clk_enable) begin
          state_d = StRampDown;
          idx_d   = LastIdx;
          cnt_d   = '0;
        end
      end
      StRampDown: begin
        if (dram_io_clk_enable) begin
          if (idx_q == LastIdx) begin
            state_d = StOn;
          end else begin
            state_d = StRampUp;
            idx_d   = idx_q + 1'b1;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!clk_value[idx_q]) begin
          gate_d[idx_q] = 1'b0;
          cnt_d         = reload;
          if (idx_q == '0) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status flags decode the next state so they line up with the gate outputs.
  always_comb begin
    busy_d = (state_d == StRampUp) || (state_d == StRampDown);
    done_d = (state_d == StOn);
  end

  // Boundary-scan register and pad output muxing.
  always_comb begin
    sr_shifted = {sr_q, bsi};
    sr_d       = sr_q;
    if (clock_dr) begin
      sr_d = shift_dr ? sr_shifted[NCLK-1:0] : pad_data_q;
    end
    // Update samples the pre-edge shift register even when clock_dr is also high.
    ur_d = update_dr ? sr_q : ur_q;

    if (mode_ctrl) begin
      pad_data_d = ur_q;
      pad_oe_d   = {NCLK{hiz_n}};
    end else begin
      pad_data_d = clk_value & gate_q;
      pad_oe_d   = '1;
    end
  end

  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      gate_q     <= '0;
      sr_q       <= '0;
      ur_q       <= '0;
      pad_data_q <= '0;
      pad_oe_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gate_q     <= gate_d;
      sr_q       <= sr_d;
      ur_q       <= ur_d;
      pad_data_q <= pad_data_d;
      pad_oe_q   <= pad_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef DDR_CLK_DIFF_EN
  logic [NCLK-1:0] pad_data_n_q, pad_data_n_d;

  // Complement follows a live channel; a gated-off functional channel parks low.
  always_comb begin
    pad_data_n_d = ({NCLK{mode_ctrl}} | gate_q) & ~pad_data_d;
  end

  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      pad_data_n_q <= '0;
    end else begin
      pad_data_n_q <= pad_data_n_d;
    end
  end

  assign pad_data_n = pad_data_n_q;
`endif

  assign bso      = sr_q[NCLK-1];
  assign pad_data = pad_data_q;
  assign pad_oe   = pad_oe_q;
  assign clk_gate = gate_q;
  assign seq_busy = busy_q;
  assign seq_done = done_q;

endmodule

// File: tb/tb_bw_io_ddr_clk_seq.sv
// tb_bw_io_ddr_clk_seq: self-checking bench for bw_io_ddr_clk_seq (NCLK=4, STAGGER_W=4).
// Expected output values are queued as stimulus is applied and compared after the
// next rclk edge.

module tb_bw_io_ddr_clk_seq;

  localparam int SelGate = 0;
  localparam int SelData = 1;
  localparam int SelOe   = 2;
  localparam int SelBso  = 3;
  localparam int SelBusy = 4;
  localparam int SelDone = 5;
  localparam int SelDiff = 6;

  logic       rclk;
  logic       rst_l;
  logic       dram_io_clk_enable;
  logic [3:0] stagger_cyc;
  logic [3:0] clk_value;
  logic       mode_ctrl;
  logic       hiz_n;
  logic       clock_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       bsi;
  logic       bso;
  logic [3:0] pad_data;
  logic [3:0] pad_oe;
  logic [3:0] clk_gate;
  logic       seq_busy;
  logic       seq_done;
`ifdef DDR_CLK_DIFF_EN
  logic [3:0] pad_data_n;
`endif

  bw_io_ddr_clk_seq #(
    .NCLK      (4),
    .STAGGER_W (4)
  ) dut (
    .rclk               (rclk),
    .rst_l              (rst_l),
    .dram_io_clk_enable (dram_io_clk_enable),
    .stagger_cyc        (stagger_cyc),
    .clk_value          (clk_value),
    .mode_ctrl          (mode_ctrl),
    .hiz_n              (hiz_n),
    .clock_dr           (clock_dr),
    .shift_dr           (shift_dr),
    .update_dr          (update_dr),
    .bsi                (bsi),
    .bso                (bso),
    .pad_data           (pad_data),
`ifdef DDR_CLK_DIFF_EN
    .pad_data_n         (pad_data_n),
`endif
    .pad_oe             (pad_oe),
    .clk_gate           (clk_gate),
    .seq_busy           (seq_busy),
    .seq_done           (seq_done)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_val(input int sel);
    case (sel)
      SelGate: return 32'(clk_gate);
      SelData: return 32'(pad_data);
      SelOe:   return 32'(pad_oe);
      SelBso:  return 32'(bso);
      SelBusy: return 32'(seq_busy);
      SelDone: return 32'(seq_done);
`ifdef DDR_CLK_DIFF_EN
      SelDiff: return 32'(pad_data_n);
`endif
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // One rclk edge, then compare everything queued for it.
  task automatic tick();
    exp_t e;
    @(posedge rclk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, obs_val(e.sel), e.exp);
    end
  endtask

  logic [3:0] up_gate [0:7];
  logic [3:0] gl_gate [0:12];
  logic       shift_bits [0:3];
  logic       shift_bso [0:3];

  initial begin
    up_gate    = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};
    gl_gate    = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h3,
                   4'h3, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0};
    shift_bits = '{1'b1, 1'b0, 1'b0, 1'b1};
    shift_bso  = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst_l = 1'b0;
    dram_io_clk_enable = 1'b0;
    stagger_cyc = 4'd2;
    clk_value = 4'h0;
    mode_ctrl = 1'b0;
    hiz_n = 1'b1;
    clock_dr = 1'b0;
    shift_dr = 1'b0;
    update_dr = 1'b0;
    bsi = 1'b0;

    // Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      dram_io_clk_enable = 1'b1;
      clk_value = 4'($urandom);
      clock_dr = i[0];
      shift_dr = i[1];
      update_dr = 1'b1;
      bsi = ~i[0];
      mode_ctrl = i[0];
      tick();
    end
    expect_out("rst_gate", SelGate, 0);
    expect_out("rst_data", SelData, 0);
    expect_out("rst_oe", SelOe, 0);
    expect_out("rst_bso", SelBso, 0);
    expect_out("rst_busy", SelBusy, 0);
    expect_out("rst_done", SelDone, 0);
    tick();

    dram_io_clk_enable = 1'b0;
    clk_value = 4'h0;
    mode_ctrl = 1'b0;
    clock_dr = 1'b0;
    shift_dr = 1'b0;
    update_dr = 1'b0;
    bsi = 1'b0;
    rst_l = 1'b1;
    tick();
    expect_out("idle_gate", SelGate, 0);
    expect_out("idle_busy", SelBusy, 0);
    expect_out("idle_done", SelDone, 0);
    expect_out("func_oe", SelOe, 4'hF);
    tick();

    // Ramp up with stagger 2.
    dram_io_clk_enable = 1'b1;
    stagger_cyc = 4'd2;
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("up_gate_e%0d", k), SelGate, 32'(up_gate[k]));
      if (k == 0) expect_out("up_busy_e0", SelBusy, 1);
      if (k == 6) expect_out("up_done_e6", SelDone, 0);
      if (k == 7) begin
        expect_out("up_done_e7", SelDone, 1);
        expect_out("up_busy_e7", SelBusy, 0);
      end
      tick();
    end

    // Functional data path, then boundary scan.
    clk_value = 4'b1010;
    expect_out("func_data", SelData, 4'hA);
`ifdef DDR_CLK_DIFF_EN
    expect_out("diff_data", SelDiff, 4'h5);
`endif
    tick();
    clock_dr = 1'b1;
    shift_dr = 1'b0;
    expect_out("cap_bso", SelBso, 1);
    tick();
    shift_dr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bsi = shift_bits[k];
      expect_out($sformatf("shift_bso_%0d", k), SelBso, 32'(shift_bso[k]));
      tick();
    end
    clock_dr = 1'b0;
    shift_dr = 1'b0;
    update_dr = 1'b1;
    expect_out("upd_bso", SelBso, 1);
    tick();
    update_dr = 1'b0;
    mode_ctrl = 1'b1;
    hiz_n = 1'b1;
    expect_out("scan_data", SelData, 4'h9);
    expect_out("scan_oe_hi", SelOe, 4'hF);
    tick();
    hiz_n = 1'b0;
    expect_out("scan_oe_lo", SelOe, 4'h0);
    expect_out("scan_data2", SelData, 4'h9);
    tick();
    // Update together with shift must load the pre-edge shift register.
    clock_dr = 1'b1;
    shift_dr = 1'b1;
    bsi = 1'b0;
    update_dr = 1'b1;
    expect_out("shupd_bso", SelBso, 0);
    tick();
    clock_dr = 1'b0;
    shift_dr = 1'b0;
    update_dr = 1'b0;
    expect_out("shupd_data", SelData, 4'h9);
    expect_out("scan_done_kept", SelDone, 1);
    tick();
    mode_ctrl = 1'b0;
    hiz_n = 1'b1;
    clk_value = 4'h0;
    expect_out("back_func_oe", SelOe, 4'hF);
    tick();

    // Ramp down with stagger 0: consecutive gate events.
    dram_io_clk_enable = 1'b0;
    stagger_cyc = 4'd0;
    expect_out("dn_done_e0", SelDone, 0);
    expect_out("dn_busy_e0", SelBusy, 1);
    expect_out("dn_gate_e0", SelGate, 4'hF);
    tick();
    expect_out("dn_gate_e1", SelGate, 4'h7);
    tick();
    expect_out("dn_gate_e2", SelGate, 4'h3);
    tick();
    expect_out("dn_gate_e3", SelGate, 4'h1);
    tick();
    expect_out("dn_gate_e4", SelGate, 4'h0);
    expect_out("dn_busy_e4", SelBusy, 0);
    tick();

    // Glitch-free wait on pad 1, then abort after gate 1 is set.
    stagger_cyc = 4'd2;
    for (int k = 0; k < 13; k++) begin
      clk_value = (k >= 3 && k <= 5) ? 4'b0010 : 4'b0000;
      dram_io_clk_enable = (k <= 6);
      expect_out($sformatf("gl_gate_e%0d", k), SelGate, 32'(gl_gate[k]));
      expect_out($sformatf("gl_data_e%0d", k), SelData, 0);
      if (k == 7) expect_out("ab_busy_e7", SelBusy, 1);
      if (k == 11) expect_out("ab_busy_e11", SelBusy, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
